rr_arbiter: RTL

Parametrised N-requester round-robin arbiter with grant hold and optional maximum-hold fairness limit. It generalises the team's 2-requester grant FSM:
- any number of requesters;
- simultaneous requests are resolved instead of all being refused;
- the grant hands over directly to the next requester with no idle cycle;
- a timeout stops one requester from monopolising the resource.

It sits between N bus/resource masters and a single shared hardware resource.

---
 rtl/arb_pkg.sv | 24 ++
 rtl/rr_pick.sv | 57 +++++
 rtl/rr_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encoding and width helper for the round-robin arbiter
//
// Purpose: common definitions imported by rr_pick and rr_arbiter.
//   arb_state_e : arbiter FSM encoding (ARB_IDLE / ARB_GRANT)
//   clog2       : ceiling log2 used to derive index and counter widths
package arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Ceiling log2, never below 1 so every derived vector keeps at least one bit
  // (MAX_HOLD=0 would otherwise give a zero-width hold counter).
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting at a pointer
//
// Purpose: find the first set bit of req scanning ptr, ptr+1, ..., N_REQ-1, 0, ...
// Ports:
//   req    in  [N_REQ-1:0] candidate requests
//   ptr    in  [IDX_W-1:0] highest-priority index
//   onehot out [N_REQ-1:0] one-hot of the picked index (zero when none)
//   idx    out [IDX_W-1:0] picked index (zero when none)
//   any    out             at least one request present
module rr_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  localparam logic [N_REQ-1:0] REQ_ONE = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [IDX_W:0]   N_WIDE  = (IDX_W+1)'(N_REQ);

  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [IDX_W:0]     offset;
  logic [IDX_W:0]     sum;

  always_comb begin
    // Doubling the vector makes the wrap-around a plain right shift:
    // rotated[0] is req[ptr], rotated[1] is req[ptr+1], and so on.
    doubled = {req, req};
    rotated = N_REQ'(doubled >> ptr);

    offset = '0;
    any    = 1'b0;
    // Scan from the top so the lowest set offset is the one left standing.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = (IDX_W+1)'(i);
        any    = 1'b1;
      end
    end

    // Convert the offset back to an absolute index, modulo N_REQ.
    sum = {1'b0, ptr} + offset;
    if (sum >= N_WIDE) begin
      sum = sum - N_WIDE;
    end

    idx    = any ? sum[IDX_W-1:0] : '0;
    onehot = any ? (REQ_ONE << idx) : '0;
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-requester round-robin arbiter with grant hold and hold limit
//
// Purpose: grants one shared resource to one of N_REQ masters; the owner keeps
// the grant while it requests, up to MAX_HOLD cycles when others are waiting
// (MAX_HOLD=0: unlimited). Outputs are decoded from registered state only.
// Ports:
//   clk       in  clock, rising edge
//   rst_n     in  asynchronous active-low reset
//   req       in  [N_REQ-1:0] request vector
//   gnt       out [N_REQ-1:0] one-hot grant, zero when idle
//   gnt_valid out             OR of gnt
//   gnt_idx   out [IDX_W-1:0] granted index, zero when idle
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int  N_REQ    = 4,
  parameter int  MAX_HOLD = 16,
  localparam int IDX_W    = clog2(N_REQ),
  localparam int CNT_W    = clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);
  localparam logic             HOLD_LIM  = (MAX_HOLD != 0);

  arb_state_e       fsm, fsm_nxt;
  logic [IDX_W-1:0] owner, owner_nxt;
  logic [N_REQ-1:0] owner_oh, owner_oh_nxt;   // one-hot copy of owner, drives gnt
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;

  logic [N_REQ-1:0] others;
  logic             owner_req;

  logic [N_REQ-1:0] all_oh, oth_oh;
  logic [IDX_W-1:0] all_idx, oth_idx;
  logic             all_any, oth_any;

  assign others    = req & ~owner_oh;
  assign owner_req = |(req & owner_oh);

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick_all (
    .req    (req),
    .ptr    (ptr),
    .onehot (all_oh),
    .idx    (all_idx),
    .any    (all_any)
  );

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick_oth (
    .req    (others),
    .ptr    (ptr),
    .onehot (oth_oh),
    .idx    (oth_idx),
    .any    (oth_any)
  );

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] k);
    return (k == LAST_IDX) ? '0 : k + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= ARB_IDLE;
      owner    <= '0;
      owner_oh <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      fsm      <= fsm_nxt;
      owner    <= owner_nxt;
      owner_oh <= owner_oh_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  always_comb begin
    fsm_nxt      = fsm;
    owner_nxt    = owner;
    owner_oh_nxt = owner_oh;
    ptr_nxt      = ptr;
    hold_cnt_nxt = hold_cnt;

    case (fsm)
      ARB_IDLE: begin
        if (all_any) begin
          fsm_nxt      = ARB_GRANT;
          owner_nxt    = all_idx;
          owner_oh_nxt = all_oh;
          ptr_nxt      = ptr_after(all_idx);
          hold_cnt_nxt = HOLD_ONE;
        end
      end

      ARB_GRANT: begin
        if (!owner_req) begin
          // Release takes priority over the hold limit; a waiting requester
          // takes over on the same edge so there is no dead cycle.
          if (oth_any) begin
            owner_nxt    = oth_idx;
            owner_oh_nxt = oth_oh;
            ptr_nxt      = ptr_after(oth_idx);
            hold_cnt_nxt = HOLD_ONE;
          end else begin
            fsm_nxt      = ARB_IDLE;
            owner_oh_nxt = '0;
            hold_cnt_nxt = '0;
          end
        end else if (HOLD_LIM && (hold_cnt == HOLD_MAX) && oth_any) begin
          owner_nxt    = oth_idx;
          owner_oh_nxt = oth_oh;
          ptr_nxt      = ptr_after(oth_idx);
          hold_cnt_nxt = HOLD_ONE;
        end else if (HOLD_LIM && (hold_cnt != HOLD_MAX)) begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end

      default: begin
        fsm_nxt      = ARB_IDLE;
        owner_oh_nxt = '0;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (fsm == ARB_GRANT) begin
      gnt       = owner_oh;
      gnt_valid = 1'b1;
      gnt_idx   = owner;
    end
  end

endmodule
